// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, and ALU operation codes.
package mips_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_RTYPEEX = 4'd6;
    localparam state_t S_RTYPEWB = 4'd7;
    localparam state_t S_BEQEX   = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JEX     = 4'd11;
    localparam state_t S_BNEEX   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_aludec.sv
// Combinational ALU decoder: aluop plus R-type funct field to alucontrol.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with slow-memory wait counter and ALU decoder.
// Optional bne support is built when MIPS_MC_BNE_EN is defined.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [3:0] WAIT_LIM = 4'(FETCH_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic       hold;
    logic       pcwrite, branch;
    logic       irwrite_c, memwrite_c, regwrite_c;
    logic [1:0] aluop;
`ifdef MIPS_MC_BNE_EN
    logic       bne_br;
`endif

    // Counter only runs while parked in FETCH/MEMRD and is zero everywhere else,
    // so it is already 0 on entry to either waiting state.
    assign hold = ((state_q == S_FETCH) || (state_q == S_MEMRD)) && (wait_cnt != WAIT_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= hold ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
`ifdef MIPS_MC_BNE_EN
        bne_br     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                if (!hold) begin
                    irwrite_c = 1'b1;
                    pcwrite   = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (!hold) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MIPS_MC_BNE_EN
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                bne_br  = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    mips_mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Write strobes are masked by reset directly so nothing fires before the clock catches up.
`ifdef MIPS_MC_BNE_EN
    assign pcen = (pcwrite | (branch & zero) | (bne_br & ~zero)) & ~reset;
`else
    assign pcen = (pcwrite | (branch & zero)) & ~reset;
`endif
    assign irwrite  = irwrite_c & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign regwrite = regwrite_c & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: FETCH_WAIT=0 and FETCH_WAIT=2 instances,
// expected per-cycle output vectors built from instruction-level rules.
module tb_mips_mc_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } vec_t;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
    localparam logic [5:0] T_J = 6'b000010;
`ifdef MIPS_MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, z0, z1;
    logic [5:0] op0, op1, fn0, fn1;
    logic       pcen0, iord0, mw0, ir0, rd0, m2r0, rw0, asa0;
    logic       pcen1, iord1, mw1, ir1, rd1, m2r1, rw1, asa1;
    logic [1:0] asb0, pcs0, asb1, pcs1;
    logic [2:0] ac0, ac1;
    logic [3:0] st0, st1;
    vec_t       obs0, obs1;

    assign obs0 = {st0, pcen0, iord0, mw0, ir0, rd0, m2r0, rw0, asa0, asb0, pcs0, ac0};
    assign obs1 = {st1, pcen1, iord1, mw1, ir1, rd1, m2r1, rw1, asa1, asb1, pcs1, ac1};

    mips_mc_controller #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .reset(rst0), .op(op0), .funct(fn0), .zero(z0),
        .pcen(pcen0), .iord(iord0), .memwrite(mw0), .irwrite(ir0), .regdst(rd0),
        .memtoreg(m2r0), .regwrite(rw0), .alusrca(asa0), .alusrcb(asb0),
        .pcsrc(pcs0), .alucontrol(ac0), .state(st0)
    );

    mips_mc_controller #(.FETCH_WAIT(2)) dut1 (
        .clk(clk), .reset(rst1), .op(op1), .funct(fn1), .zero(z1),
        .pcen(pcen1), .iord(iord1), .memwrite(mw1), .irwrite(ir1), .regdst(rd1),
        .memtoreg(m2r1), .regwrite(rw1), .alusrca(asa1), .alusrcb(asb1),
        .pcsrc(pcs1), .alucontrol(ac1), .state(st1)
    );

    int   total = 0;
    int   bad = 0;
    vec_t q0[$];
    vec_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic vec_t base(input logic [3:0] s);
        vec_t v;
        v = '0;
        v.state = s;
        v.alucontrol = 3'b010;
        return v;
    endfunction

    // Expected outputs per cycle for one whole instruction; keep>0 truncates the list.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int keep);
        vec_t e[$];
        vec_t v;
        int   fw;
        int   n;
        fw = (k == 0) ? 0 : 2;
        for (int c = 0; c <= fw; c++) begin
            v = base(4'd0);
            v.alusrcb = 2'b01;
            if (c == fw) begin
                v.irwrite = 1'b1;
                v.pcen = 1'b1;
            end
            e.push_back(v);
        end
        v = base(4'd1);
        v.alusrcb = 2'b11;
        e.push_back(v);
        if (op == T_LW || op == T_SW) begin
            v = base(4'd2);
            v.alusrca = 1'b1;
            v.alusrcb = 2'b10;
            e.push_back(v);
            if (op == T_LW) begin
                for (int c = 0; c <= fw; c++) begin
                    v = base(4'd3);
                    v.iord = 1'b1;
                    e.push_back(v);
                end
                v = base(4'd4);
                v.memtoreg = 1'b1;
                v.regwrite = 1'b1;
                e.push_back(v);
            end else begin
                v = base(4'd5);
                v.iord = 1'b1;
                v.memwrite = 1'b1;
                e.push_back(v);
            end
        end else if (op == T_R) begin
            v = base(4'd6);
            v.alusrca = 1'b1;
            v.alucontrol = ref_alu(fn);
            e.push_back(v);
            v = base(4'd7);
            v.regdst = 1'b1;
            v.regwrite = 1'b1;
            e.push_back(v);
        end else if (op == T_BEQ || (BNE_EN && op == T_BNE)) begin
            v = base((op == T_BEQ) ? 4'd8 : 4'd12);
            v.alusrca = 1'b1;
            v.alucontrol = 3'b110;
            v.pcsrc = 2'b01;
            v.pcen = (op == T_BEQ) ? z : ~z;
            e.push_back(v);
        end else if (op == T_ADDI) begin
            v = base(4'd9);
            v.alusrca = 1'b1;
            v.alusrcb = 2'b10;
            e.push_back(v);
            v = base(4'd10);
            v.regwrite = 1'b1;
            e.push_back(v);
        end else if (op == T_J) begin
            v = base(4'd11);
            v.pcsrc = 2'b10;
            v.pcen = 1'b1;
            e.push_back(v);
        end
        n = (keep > 0 && keep < e.size()) ? keep : e.size();
        if (k == 0) begin
            op0 = op; fn0 = fn; z0 = z;
            for (int i = 0; i < n; i++) q0.push_back(e[i]);
        end else begin
            op1 = op; fn1 = fn; z1 = z;
            for (int i = 0; i < n; i++) q1.push_back(e[i]);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int k, input int count);
        logic [5:0] ops [9];
        logic [5:0] fns [6];
        logic [31:0] r;
        logic [5:0] op, fn;
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_BNE, 6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int i = 0; i < count; i++) begin
            r = $urandom();
            op = (r[31:28] == 4'hf) ? r[5:0] : ops[$urandom_range(0, 7)];
            fn = (r[27:26] == 2'b11) ? r[11:6] : fns[$urandom_range(0, 4)];
            run_instr(k, op, fn, r[20], 0);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) chk("dut0_cycle", 32'(obs0), 32'(q0.pop_front()));
        if (q1.size() > 0) chk("dut1_cycle", 32'(obs1), 32'(q1.pop_front()));
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        rst0 = 1'b1; rst1 = 1'b1;
        op0 = '0; op1 = '0; fn0 = '0; fn1 = '0; z0 = 1'b0; z1 = 1'b0;
        rv = base(4'd0);
        rv.alusrcb = 2'b01;
        #3;
        chk("reset_dut0", 32'(obs0), 32'(rv));
        chk("reset_dut1", 32'(obs1), 32'(rv));

        @(posedge clk); #1;
        rst0 = 1'b0;
        run_instr(0, T_LW, 6'b000000, 1'b0, 0);
        run_instr(0, T_R, 6'b100000, 1'b0, 0);
        run_instr(0, T_R, 6'b101010, 1'b0, 0);
        run_instr(0, T_BEQ, 6'b000000, 1'b1, 0);
        run_instr(0, T_BEQ, 6'b000000, 1'b0, 0);
        run_instr(0, 6'b111111, 6'b000000, 1'b0, 0);
        run_instr(0, T_BNE, 6'b000000, 1'b0, 0);
        run_instr(0, T_J, 6'b000000, 1'b0, 0);
        run_random(0, 120);

        // Reset arriving mid-store must kill memwrite without waiting for a clock.
        run_instr(0, T_SW, 6'b000000, 1'b0, 3);
        chk("memwr_before_reset", {28'd0, st0}, 32'd5);
        chk("memwrite_before_reset", {31'd0, mw0}, 32'd1);
        #2 rst0 = 1'b1;
        #1;
        chk("memwr_reset_async", 32'(obs0), 32'(rv));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold_dut0", 32'(obs0), 32'(rv));
        end
        @(posedge clk); #1;
        rst0 = 1'b0;
        run_instr(0, T_ADDI, 6'b000000, 1'b0, 0);

        rst1 = 1'b0;
        run_instr(1, T_LW, 6'b000000, 1'b0, 0);
        run_instr(1, T_SW, 6'b000000, 1'b0, 0);
        run_instr(1, T_R, 6'b100100, 1'b0, 0);
        run_random(1, 60);

        if (q0.size() != 0 || q1.size() != 0) chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
